// File: rtl/uart_echo_ctrl.sv
// uart_echo_ctrl: captures receiver frames, filters error bytes, buffers them and echoes them to the transmitter.
// Optional macro UART_ECHO_CRLF_EN: after a 0x0D byte completes, insert one 0x0A before the next FIFO byte.
module uart_echo_ctrl #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int DROP_ERR = 1,
    parameter int BUSY_TMO = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_rdsig,
    input  logic          rx_dataerror,
    input  logic          rx_framerror,
    output logic [7:0]    tx_data,
    output logic          tx_wrsig,
    input  logic          tx_busy,
    output logic [AW:0]   fifo_count,
    output logic          overflow,
    output logic [7:0]    err_count
);
    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [15:0]   tmo;
    logic          rd_q, rise, err, push, pop, wr, full, empty;
`ifdef UART_ECHO_CRLF_EN
    logic          lf_pend;
`endif

    assign rise  = rx_rdsig & ~rd_q;
    assign err   = rx_dataerror | rx_framerror;
    assign push  = rise & (~err | (DROP_ERR == 0));
    assign full  = fifo_count == (AW+1)'(DEPTH);
    assign empty = fifo_count == '0;
`ifdef UART_ECHO_CRLF_EN
    assign pop   = (state == IDLE) & ~empty & ~lf_pend;
`else
    assign pop   = (state == IDLE) & ~empty;
`endif
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
    assign wr    = push & (~full | pop);

    // Rising-edge detect on rdsig; resets high so an rdsig already asserted is ignored
    always_ff @(posedge clk) begin
        rd_q <= rst ? 1'b1 : rx_rdsig;
        if (rst)
            err_count <= '0;
        else if (rise & err & (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_ptr] <= rx_data;
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push & full & ~pop)
                overflow <= 1'b1;
            fifo_count <= fifo_count + (AW+1)'(wr) - (AW+1)'(pop);
        end
    end

    // Transmit sequencer: load byte, pulse start, wait for busy (or time out), wait for done
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_data  <= 8'h00;
            tx_wrsig <= 1'b0;
            tmo      <= '0;
`ifdef UART_ECHO_CRLF_EN
            lf_pend  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef UART_ECHO_CRLF_EN
                    if (lf_pend) begin
                        tx_data  <= 8'h0A;
                        lf_pend  <= 1'b0;
                        tx_wrsig <= 1'b1;
                        state    <= START;
                    end else if (pop) begin
                        tx_data  <= mem[rd_ptr];
                        lf_pend  <= mem[rd_ptr] == 8'h0D;
                        tx_wrsig <= 1'b1;
                        state    <= START;
                    end
`else
                    if (pop) begin
                        tx_data  <= mem[rd_ptr];
                        tx_wrsig <= 1'b1;
                        state    <= START;
                    end
`endif
                end
                START: begin
                    tx_wrsig <= 1'b0;
                    tmo      <= '0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy)
                        state <= WAIT_DONE;
                    else if (tmo == 16'(BUSY_TMO - 1))
                        state <= IDLE;
                    else
                        tmo <= tmo + 16'd1;
                end
                WAIT_DONE: begin
                    if (!tx_busy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_echo_ctrl.sv
// tb_uart_echo_ctrl: directed table-driven and sequence checks for uart_echo_ctrl.
module tb_uart_echo_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_rdsig = 1'b0;
    logic       rx_dataerror = 1'b0;
    logic       rx_framerror = 1'b0;
    logic [7:0] tx_data;
    logic       tx_wrsig;
    logic       tx_busy = 1'b0;
    logic [4:0] fifo_count;
    logic       overflow;
    logic [7:0] err_count;

    int pass = 0;
    int total = 0;
    int cyc = 0;
    logic [7:0] txq[$];
    int tcyc[$];

    typedef struct {
        logic [7:0] d;
        logic       de;
        logic       fe;
        int         len;
        logic       sent;
        int         errs;
    } vec_t;
    vec_t v[7];

    uart_echo_ctrl dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdsig(rx_rdsig),
        .rx_dataerror(rx_dataerror), .rx_framerror(rx_framerror),
        .tx_data(tx_data), .tx_wrsig(tx_wrsig), .tx_busy(tx_busy),
        .fifo_count(fifo_count), .overflow(overflow), .err_count(err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (!rst && tx_wrsig) begin
        txq.push_back(tx_data);
        tcyc.push_back(cyc);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic send(input logic [7:0] d, input logic de, input logic fe, input int len);
        rx_data = d;
        rx_dataerror = de;
        rx_framerror = fe;
        rx_rdsig = 1'b1;
        tick(len);
        rx_rdsig = 1'b0;
        rx_dataerror = 1'b0;
        rx_framerror = 1'b0;
        tick();
    endtask

    initial begin
        int n0;
        v[0] = '{8'h55, 1'b0, 1'b0, 2, 1'b1, 0};
        v[1] = '{8'h41, 1'b1, 1'b0, 1, 1'b0, 1};
        v[2] = '{8'h42, 1'b0, 1'b1, 3, 1'b0, 2};
        v[3] = '{8'h43, 1'b0, 1'b0, 1, 1'b1, 2};
        v[4] = '{8'h00, 1'b1, 1'b1, 1, 1'b0, 3};
        v[5] = '{8'hFF, 1'b0, 1'b0, 5, 1'b1, 3};
        v[6] = '{8'h0A, 1'b0, 1'b0, 1, 1'b1, 3};

        tick(3);
        rst = 1'b0;
        tick();
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_tx_wrsig", int'(tx_wrsig), 0);
        chk("rst_fifo_count", int'(fifo_count), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_err_count", int'(err_count), 0);

        // Latency: push in cycle N, pop N+1, start pulse N+2, pulse lasts one cycle
        rx_data = 8'h55;
        rx_rdsig = 1'b1;
        tick();
        chk("lat_n1_wrsig", int'(tx_wrsig), 0);
        chk("lat_n1_count", int'(fifo_count), 1);
        tick();
        chk("lat_n2_wrsig", int'(tx_wrsig), 1);
        chk("lat_n2_data", int'(tx_data), 8'h55);
        chk("lat_n2_count", int'(fifo_count), 0);
        rx_rdsig = 1'b0;
        tick();
        chk("lat_n3_wrsig", int'(tx_wrsig), 0);
        tick(12);
        chk("single_pulses", txq.size(), 1);
        chk("single_err", int'(err_count), 0);

        // Table of frames with error filtering
        for (int i = 0; i < 7; i++) begin
            n0 = txq.size();
            send(v[i].d, v[i].de, v[i].fe, v[i].len);
            tick(14);
            chk("vec_sent", txq.size() - n0, v[i].sent ? 1 : 0);
            if (v[i].sent && txq.size() > 0) chk("vec_data", int'(txq[txq.size()-1]), int'(v[i].d));
            chk("vec_err", int'(err_count), v[i].errs);
            chk("vec_count", int'(fifo_count), 0);
        end

        // Busy timeout: three queued bytes, pulses 10 cycles apart
        n0 = txq.size();
        send(8'h11, 1'b0, 1'b0, 1);
        send(8'h22, 1'b0, 1'b0, 1);
        send(8'h33, 1'b0, 1'b0, 1);
        tick(40);
        chk("tmo_pulses", txq.size() - n0, 3);
        if (txq.size() >= n0 + 3) begin
            chk("tmo_b0", int'(txq[n0]), 8'h11);
            chk("tmo_b1", int'(txq[n0+1]), 8'h22);
            chk("tmo_b2", int'(txq[n0+2]), 8'h33);
            chk("tmo_gap01", tcyc[n0+1] - tcyc[n0], 10);
            chk("tmo_gap12", tcyc[n0+2] - tcyc[n0+1], 10);
        end

        // Error counter saturation
        for (int i = 0; i < 260; i++) send(8'hEE, 1'b1, 1'b0, 1);
        chk("err_sat", int'(err_count), 255);
        chk("err_sat_count", int'(fifo_count), 0);

        // Overflow with transmitter held busy
        tx_busy = 1'b1;
        n0 = txq.size();
        for (int i = 0; i < 16; i++) send(8'h80 + 8'(i), 1'b0, 1'b0, 1);
        tick(5);
        chk("ovf_count15", int'(fifo_count), 15);
        chk("ovf_clear", int'(overflow), 0);
        send(8'h90, 1'b0, 1'b0, 1);
        send(8'h91, 1'b0, 1'b0, 1);
        chk("ovf_count16", int'(fifo_count), 16);
        chk("ovf_set", int'(overflow), 1);
        tx_busy = 1'b0;
        tick(300);
        chk("ovf_echoed", txq.size() - n0, 17);
        if (txq.size() >= n0 + 17)
            for (int i = 0; i < 17; i++) chk("ovf_order", int'(txq[n0+i]), i < 16 ? 8'h80 + i : 8'h90);
        chk("ovf_drained", int'(fifo_count), 0);
        chk("ovf_sticky", int'(overflow), 1);

        // Reset during WAIT_DONE with rdsig held through reset
        tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), 1'b0, 1'b0, 1);
        tick(4);
        chk("mid_count", int'(fifo_count), 4);
        rst = 1'b1;
        rx_rdsig = 1'b1;
        rx_data = 8'h77;
        tick();
        chk("mid_wrsig", int'(tx_wrsig), 0);
        chk("mid_count0", int'(fifo_count), 0);
        chk("mid_ovf0", int'(overflow), 0);
        chk("mid_err0", int'(err_count), 0);
        rst = 1'b0;
        tick(3);
        tx_busy = 1'b0;
        rx_rdsig = 1'b0;
        n0 = txq.size();
        tick(40);
        chk("mid_no_pulse", txq.size() - n0, 0);
        chk("mid_no_capture", int'(fifo_count), 0);

        // CR handling
        n0 = txq.size();
        send(8'h31, 1'b0, 1'b0, 1);
        send(8'h0D, 1'b0, 1'b0, 1);
        tick(60);
`ifdef UART_ECHO_CRLF_EN
        chk("crlf_n", txq.size() - n0, 3);
        if (txq.size() >= n0 + 3) chk("crlf_lf", int'(txq[n0+2]), 8'h0A);
`else
        chk("crlf_n", txq.size() - n0, 2);
`endif
        if (txq.size() >= n0 + 2) begin
            chk("crlf_b0", int'(txq[n0]), 8'h31);
            chk("crlf_b1", int'(txq[n0+1]), 8'h0D);
        end
        chk("crlf_count", int'(fifo_count), 0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
